iir_cfg_ctrl: RTL

Configuration controller for the three-stage cascaded biquad IIR filter. It accepts coefficient and order writes over a valid/ready port into a shadow bank. On a commit request it copies the shadow bank into the active bank that drives the filter's b0..b8, a1..a6 and order inputs. It then holds the filter in reset for a fixed flush window so no stale section state survives a reconfiguration.

---
 rtl/iir_cfg_pkg.sv | 17 +
 rtl/iir_cfg_ctrl_if.sv | 10 +
 rtl/iir_coef_bank.sv | 45 ++++
 rtl/iir_cfg_ctrl.sv | 110 +++++++++++
 4 files changed

// File: rtl/iir_cfg_pkg.sv
// Shared types and constants for the IIR configuration controller.
package iir_cfg_pkg;

  typedef enum logic [1:0] {IDLE, APPLY, FLUSH, RUN} state_t;

  localparam logic [3:0]  ADDR_B0    = 4'd0;
  localparam logic [3:0]  ADDR_A1    = 4'd9;
  localparam logic [3:0]  ADDR_ORDER = 4'd15;
  localparam int unsigned NUM_COEF   = 15;
  localparam logic [3:0]  ORDER_MIN  = 4'd1;
  localparam logic [3:0]  ORDER_MAX  = 4'd3;

  function automatic logic order_ok(input logic [3:0] ord);
    return (ord >= ORDER_MIN) && (ord <= ORDER_MAX);
  endfunction

endpackage

// File: rtl/iir_cfg_ctrl_if.sv
// Coefficient write port: valid/ready handshake with address and data.
interface iir_cfg_ctrl_if #(parameter int unsigned W = 16);
  logic         wr_valid;
  logic         wr_ready;
  logic [3:0]   wr_addr;
  logic [W-1:0] wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/iir_coef_bank.sv
// Shadow and active coefficient/order registers; the copy strobe moves shadow into active.
module iir_coef_bank
  import iir_cfg_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             i_wr_en,
  input  logic [3:0]                       i_wr_addr,
  input  logic [W-1:0]                     i_wr_data,
  input  logic                             i_copy,
  output logic [3:0]                       o_shadow_order,
  output logic [NUM_COEF-1:0][W-1:0]       o_active,
  output logic [3:0]                       o_order
);

  logic [NUM_COEF-1:0][W-1:0] r_shadow;
  logic [NUM_COEF-1:0][W-1:0] r_active;
  logic [3:0]                 r_shadow_order;
  logic [3:0]                 r_order;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow       <= '0;
      r_active       <= '0;
      r_shadow_order <= '0;
      r_order        <= '0;
    end else begin
      if (i_wr_en) begin
        if (i_wr_addr == ADDR_ORDER) r_shadow_order <= i_wr_data[3:0];
        else                         r_shadow[i_wr_addr] <= i_wr_data;
      end
      if (i_copy) begin
        r_active <= r_shadow;
        r_order  <= r_shadow_order;
      end
    end
  end

  assign o_shadow_order = r_shadow_order;
  assign o_active       = r_active;
  assign o_order        = r_order;

endmodule

// File: rtl/iir_cfg_ctrl.sv
// Configuration controller: shadow writes, commit with order check, apply and filter flush window.
module iir_cfg_ctrl
  import iir_cfg_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 4,
  parameter int unsigned W            = 16
) (
  input  logic                clk,
  input  logic                reset,
  iir_cfg_ctrl_if.slave       wr,
  input  logic                commit,
  output logic                busy,
  output logic                err,
  output logic                filt_rst_n,
  output logic signed [W-1:0] b0, b1, b2, b3, b4, b5, b6, b7, b8,
  output logic signed [W-1:0] a1, a2, a3, a4, a5, a6,
  output logic [3:0]          order
);

  localparam int unsigned CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  state_t                     r_state;
  logic [CW-1:0]              r_cnt;
  logic                       r_busy;
  logic                       r_err;
  logic                       r_filt_rst_n;
  logic                       w_wr_xfer;
  logic [3:0]                 w_shadow_order;
  logic [3:0]                 w_order_eff;
  logic [NUM_COEF-1:0][W-1:0] w_active;

  assign wr.wr_ready = (r_state == IDLE) || (r_state == RUN);
  assign w_wr_xfer   = wr.wr_valid && wr.wr_ready;

  // A same-cycle order write must be seen by the commit range check.
  assign w_order_eff = (w_wr_xfer && (wr.wr_addr == ADDR_ORDER)) ? wr.wr_data[3:0]
                                                                 : w_shadow_order;

  iir_coef_bank #(.W(W)) u_bank (
    .clk            (clk),
    .rst_n          (reset),
    .i_wr_en        (w_wr_xfer),
    .i_wr_addr      (wr.wr_addr),
    .i_wr_data      (wr.wr_data),
    .i_copy         (r_state == APPLY),
    .o_shadow_order (w_shadow_order),
    .o_active       (w_active),
    .o_order        (order)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_busy       <= 1'b0;
      r_err        <= 1'b0;
      r_filt_rst_n <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        IDLE, RUN: begin
          if (commit) begin
            if (order_ok(w_order_eff)) begin
              r_state      <= APPLY;
              r_busy       <= 1'b1;
              r_filt_rst_n <= 1'b0;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        APPLY: begin
          r_state <= FLUSH;
          r_cnt   <= CW'(FLUSH_CYCLES - 1);
        end
        FLUSH: begin
          if (r_cnt == '0) begin
            r_state      <= RUN;
            r_busy       <= 1'b0;
            r_filt_rst_n <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy       = r_busy;
  assign err        = r_err;
  assign filt_rst_n = r_filt_rst_n;

  assign b0 = w_active[ADDR_B0];
  assign b1 = w_active[ADDR_B0 + 4'd1];
  assign b2 = w_active[ADDR_B0 + 4'd2];
  assign b3 = w_active[ADDR_B0 + 4'd3];
  assign b4 = w_active[ADDR_B0 + 4'd4];
  assign b5 = w_active[ADDR_B0 + 4'd5];
  assign b6 = w_active[ADDR_B0 + 4'd6];
  assign b7 = w_active[ADDR_B0 + 4'd7];
  assign b8 = w_active[ADDR_B0 + 4'd8];
  assign a1 = w_active[ADDR_A1];
  assign a2 = w_active[ADDR_A1 + 4'd1];
  assign a3 = w_active[ADDR_A1 + 4'd2];
  assign a4 = w_active[ADDR_A1 + 4'd3];
  assign a5 = w_active[ADDR_A1 + 4'd4];
  assign a6 = w_active[ADDR_A1 + 4'd5];

endmodule
